// File: rtl/led_scan_pkg.sv
// Shared types and constants for the led_scan_decoder running-light monitor.
package led_scan_pkg;

    localparam int unsigned NUM_LEDS = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_PATTERN = 2'd1;
    localparam logic [1:0] ERR_JUMP    = 2'd2;
    localparam logic [1:0] ERR_STALL   = 2'd3;

    // True when exactly one LED is lit; all-dark and multi-hot are both rejected.
    function automatic logic is_onehot(input logic [NUM_LEDS-1:0] v);
        return (v != '0) && ((v & (v - {{(NUM_LEDS-1){1'b0}}, 1'b1})) == '0);
    endfunction

    // 1-based position of the highest lit LED; 0 when dark.
    function automatic logic [2:0] led_index(input logic [NUM_LEDS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            if (v[i]) begin
                idx = 3'(i + 1);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/led_sync.sv
// Multi-bit flop-chain synchronizer with asynchronous active-low reset.
module led_sync #(
    parameter int unsigned WIDTH  = 7,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift the raw lines through STAGES flops to resolve metastability.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/led_scan_decoder.sv
// Receive-side monitor for a 7-LED running light: tracks the lit position,
// step direction and completed laps, and latches the first protocol error.
// Optional stall timeout enabled by defining LED_SCAN_TIMEOUT_EN.
module led_scan_decoder
    import led_scan_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LAP_W       = 8,
    parameter int unsigned HOLD_MAX    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             led_1,
    input  logic             led_2,
    input  logic             led_3,
    input  logic             led_4,
    input  logic             led_5,
    input  logic             led_6,
    input  logic             led_7,
    output logic [2:0]       pos,
    output logic             valid,
    output logic             step,
    output logic             dir,
    output logic [LAP_W-1:0] lap_cnt,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam logic [2:0] POS_FIRST = 3'd1;
    localparam logic [2:0] POS_LAST  = 3'(NUM_LEDS);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("led_scan_decoder: SYNC_STAGES must be at least 2");
    end
    if (HOLD_MAX < 1) begin : g_bad_hold
        $error("led_scan_decoder: HOLD_MAX must be at least 1");
    end

    logic [NUM_LEDS-1:0] led_raw;
    logic [NUM_LEDS-1:0] led_s;
    logic                legal;
    logic [2:0]          idx;

    state_t              state_q, state_d;
    logic [2:0]          pos_q, pos_d;
    logic                valid_q, valid_d;
    logic                step_q, step_d;
    logic                dir_q, dir_d;
    logic [LAP_W-1:0]    lap_q, lap_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;
    logic                fault;
    logic [1:0]          cause;

    assign led_raw = {led_7, led_6, led_5, led_4, led_3, led_2, led_1};

    led_sync #(
        .WIDTH  (NUM_LEDS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (led_raw),
        .q   (led_s)
    );

    // The last synchronizer flop serves as the decode register, so the
    // input-to-output latency is SYNC_STAGES+1 edges.
    assign legal = is_onehot(led_s);
    assign idx   = led_index(led_s);

`ifdef LED_SCAN_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(HOLD_MAX + 1);
    logic [STALL_W-1:0] stall_q, stall_d;

    // Stall counter register; only advances while holding in TRACK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

    // Next-state and next-output logic; clr overrides every transition.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        lap_d   = lap_q;
        err_d   = err_q;
        code_d  = code_q;
        fault   = 1'b0;
        cause   = ERR_NONE;
`ifdef LED_SCAN_TIMEOUT_EN
        stall_d = '0;
`endif
        if (clr) begin
            state_d = IDLE;
            pos_d   = '0;
            dir_d   = 1'b0;
            lap_d   = '0;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (legal) begin
                        state_d = TRACK;
                        pos_d   = idx;
                    end
                end
                TRACK: begin
                    if (!legal) begin
                        fault = 1'b1;
                        cause = ERR_PATTERN;
                    end else if (idx == pos_q) begin
`ifdef LED_SCAN_TIMEOUT_EN
                        if (stall_q == STALL_W'(HOLD_MAX - 1)) begin
                            fault = 1'b1;
                            cause = ERR_STALL;
                        end else begin
                            stall_d = stall_q + STALL_W'(1);
                        end
`endif
                    end else if (pos_q == POS_LAST && idx == POS_FIRST) begin
                        pos_d  = idx;
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                        if (lap_q != '1) lap_d = lap_q + LAP_W'(1);
                    end else if (pos_q == POS_FIRST && idx == POS_LAST) begin
                        pos_d  = idx;
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                        if (lap_q != '1) lap_d = lap_q + LAP_W'(1);
                    end else if (idx == pos_q + 3'd1) begin
                        pos_d  = idx;
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                    end else if (idx == pos_q - 3'd1) begin
                        pos_d  = idx;
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                    end else begin
                        fault = 1'b1;
                        cause = ERR_JUMP;
                    end
                end
                FAULT: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (fault) begin
            state_d = FAULT;
            pos_d   = '0;
            err_d   = 1'b1;
            if (!err_q) code_d = cause;
        end

        valid_d = (state_d == TRACK);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            lap_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            lap_q   <= lap_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign pos      = pos_q;
    assign valid    = valid_q;
    assign step     = step_q;
    assign dir      = dir_q;
    assign lap_cnt  = lap_q;
    assign err      = err_q;
    assign err_code = code_q;

endmodule

// File: doc/led_scan_decoder.md
# led_scan_decoder

Receive-side monitor for the 7-LED running-light interface. It samples the seven asynchronous LED lines and checks that they form a legal running light. It reports the lit position, step direction, completed laps and the first protocol error. It sits at the consuming end of a `light_7` pattern generator, on a board or as a self-checking monitor in benches.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth per LED line (min 2).
- `LAP_W`, 8: width of the lap counter.
- `HOLD_MAX`, 16: stall limit in cycles; used only with `LED_SCAN_TIMEOUT_EN`.
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear: error, lap counter, return to IDLE.
- `led_1` … `led_7`  in  1 each  LED lines; asynchronous to `clk`; led_1 is position 1.
- `pos`  out  3  lit position 1..7; 0 = not tracking.
- `valid`  out  1  high while state is TRACK.
- `step`  out  1  one-cycle pulse when `pos` changes legally.
- `dir`  out  1  last step direction: 1 = up (toward 7), 0 = down.
- `lap_cnt`  out  LAP_W  completed wraps, saturating at all-ones.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  0 none, 1 illegal pattern, 2 bad jump, 3 stall timeout.

## Operation
- Each LED line passes through a `SYNC_STAGES` flop chain. The decode stage registers the synchronized 7-bit vector and computes the one-hot index.
- A pattern is legal only if exactly one LED is lit. All-dark and multi-hot are both illegal.
- States: IDLE, TRACK, FAULT.
- IDLE to TRACK: on the first legal pattern. Load `pos` and set `valid` = 1. No `step`; `dir` and `lap_cnt` are unchanged.
- IDLE with an illegal pattern: stay in IDLE, no error. This lets the generator come out of reset.
- TRACK, same index as `pos`: hold.
- TRACK, index = pos±1 (no wrap): update `pos`, pulse `step`, set `dir` to match the move.
- TRACK, wrap 7→1: pulse `step`, `dir` = 1, `lap_cnt`+1.
- TRACK, wrap 1→7: pulse `step`, `dir` = 0, `lap_cnt`+1.
- TRACK, any other index change: go to FAULT with `err_code` = 2.
- TRACK, illegal pattern: go to FAULT with `err_code` = 1.
- On entering FAULT: `err` = 1, `valid` = 0, `pos` = 0. `err_code` latches the first cause only.
- FAULT: stay until `clr`. `clr` returns the block to IDLE and zeroes `err`, `err_code`, `lap_cnt`, `pos` and `dir`.
- `clr` has priority over any same-cycle transition or fault, from every state.
- `lap_cnt` saturates and never wraps.

## Timing
- All outputs are registered. Reset values: `pos` = 0, `valid` = 0, `step` = 0, `dir` = 0, `lap_cnt` = 0, `err` = 0, `err_code` = 0, state IDLE, synchronizer flops 0.
- Latency: an LED change that is stable before clock edge N appears on the outputs after edge N+SYNC_STAGES. That is SYNC_STAGES+1 edges, i.e. 3 with the default depth.
- `step` is high for exactly one cycle per legal move. Back-to-back moves on consecutive cycles give consecutive pulses.
- A fault is visible on `err` in the same cycle that `valid` drops.
- `rst` asserted mid-operation clears every flop immediately, regardless of `clk`. Deassertion is synchronized externally.

## Configuration
- `LED_SCAN_TIMEOUT_EN` defined: a stall counter runs in TRACK.
  - It clears on every `step` and every state change.
  - If `pos` stays unchanged for `HOLD_MAX` consecutive cycles, the block goes to FAULT with `err_code` = 3.
- `LED_SCAN_TIMEOUT_EN` undefined: no stall counter, `err_code` never equals 3, and `HOLD_MAX` is ignored.

## Structure
- `led_scan_pkg` holds:
  - the state enum (IDLE/TRACK/FAULT);
  - error-code constants ERR_NONE/ERR_PATTERN/ERR_JUMP/ERR_STALL;
  - `NUM_LEDS` = 7.
- Sub-module `led_sync`: a parameterized multi-bit synchronizer (width 7, `SYNC_STAGES` deep, async active-low reset). It is instantiated once.
- The one-hot check and index encode are combinational inside the top module, followed by the FSM registers.

## Test plan
- Reset then a walking pattern led_1→led_7→led_1 with 4 cycles per position -> `valid` rises 3 cycles after led_1; 7 `step` pulses; `dir` = 1; `lap_cnt` = 1; `err` = 0.
- Reverse walk 7→1→7 -> `dir` = 0 after the first step; `lap_cnt` increments on 1→7; no error.
- While tracking at pos 3, drive led_3 and led_4 together -> `err` = 1, `err_code` = 1, `pos` = 0, `valid` = 0. Then `clr` -> IDLE with all outputs 0.
- At pos 2, jump to led_5 -> `err_code` = 2. A later illegal pattern leaves `err_code` at 2 (first cause is kept).
- All LEDs dark after reset for 20 cycles, then led_4 -> no error; `valid` rises with `pos` = 4; no `step` pulse.
- With `LED_SCAN_TIMEOUT_EN` and `HOLD_MAX` = 16: hold led_6 for 20 cycles -> `err_code` = 3, 16 cycles after entering TRACK. Assert `clr` in the same cycle as the fault -> `err` stays 0.
